alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Parametrised, multi-cycle successor to the accumulator-machine ALU.
- Sits between the register file and the accumulator in the datapath.
- Holds its own carry flag register, so the external overflow in/out loop is no longer needed.
- Runs shifts bit-serially and adds an iterative shift-add multiply.
- Controller issues one operation per start pulse and waits for the done pulse.

Parameters:
- W, 8, datapath width in bits (W >= 2).
- SW, $clog2(W)+1, width of the shift-amount counter; derived, not overridden.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  accept a new operation (ignored while busy).
- OP  input  4  opcode, sampled with start.
- Acc_in  input  W  accumulator operand A, sampled with start.
- Reg_in  input  W  register operand R, sampled with start.
- OUT  output  W  result register; holds its value until the next accepted op.
- c_flag  output  1  carry/overflow flag register.
- busy  output  1  high while a multi-cycle op is iterating.
- done  output  1  one-cycle pulse: OUT/c_flag now hold the final result.

Behaviour:
- Reset values: OUT=0, c_flag=0, busy=0, done=0, FSM=IDLE. Reset wins over start and aborts any op in flight; no partial result is visible.
- FSM states:
  - IDLE: start=1 latches OP/A/R. A single-cycle op writes OUT/c_flag and pulses done at the same edge, staying in IDLE. A multi-cycle op with nonzero count goes to RUN.
  - RUN: busy=1, one iteration per cycle. Returns to IDLE at the edge that writes the final result and pulses done.
- start is ignored in RUN. start in the cycle done is high is legal: back-to-back issue.
- Latency is measured from the edge sampling start to the edge asserting done:
  - single-cycle ops: 1
  - SHL/SHR: max(1, min(R, W))
  - MUL: W
- Opcodes (A, R unsigned W-bit unless stated):
  - 0000 PASSR: OUT=R.
  - 0001 PASSA: OUT=A.
  - 0010 XOR: OUT=A^R.
  - 0011 NAND: OUT=~(A&R), bitwise.
  - 0100 SHL: OUT=A<<R, one bit per cycle in RUN. R>=W gives OUT=0 after W cycles. R=0 gives OUT=A in 1 cycle.
  - 0101 SHR: logical, same timing and edge rules as SHL.
  - 0110 LSN: OUT=1 if signed(A)<signed(R), else 0. Must be correct across sign boundaries, not an MSB-of-difference shortcut.
  - 0111 EQL: OUT=(A==R)?1:0.
  - 1000 ADD: {c_flag,OUT}=A+R+c_flag (W+1-bit sum).
  - 1001 SUB: OUT=A-R mod 2^W; c_flag unchanged.
  - 1010 CLRC: c_flag=0; OUT unchanged.
  - 1011 MUL: shift-add over W cycles using a 2W-bit product. OUT=product[W-1:0]; c_flag=1 if product[2W-1:W]!=0, else 0.
  - 1100–1111 reserved: OUT=0, c_flag unchanged, done after 1 cycle.
- c_flag is modified only by ADD, CLRC, MUL and reset.
- Operand inputs may change freely after the start cycle; the block uses only its latched copies.

Test Plan:
- W=8, reset held 2 cycles, then released → OUT=0x00, c_flag=0, busy=0, done=0. Pulse start with OP=0000, R=0x5A → done 1 cycle later, OUT=0x5A.
- ADD chain: CLRC; ADD A=0xFF R=0x01 → OUT=0x00, c_flag=1; then ADD A=0x10 R=0x20 → OUT=0x31, c_flag=0.
- SHL A=0x81 R=3 → busy for the iteration cycles, done exactly 3 cycles after start, OUT=0x08. SHR A=0x81 R=9 → done after 8 cycles, OUT=0x00. SHL R=0 → 1 cycle, OUT=0x81.
- MUL A=13 R=20 → done after 8 cycles, OUT=0x04, c_flag=1. MUL A=7 R=9 → OUT=0x3F, c_flag=0. Assert start again mid-RUN → ignored, result unchanged.
- LSN/EQL: LSN A=0x80 R=0x01 → 1. LSN A=0x7F R=0x80 → 0. EQL A=R=0xC3 → 1. NAND A=0xF0 R=0xFF → 0x0F.
- Reset at cycle 4 of MUL → next cycle busy=0, done=0, OUT=0, c_flag=0. A fresh start completes normally. Also issue back-to-back start during a done pulse → the second op is accepted.

Source files
------------

// File: rtl/alu_seq_if.sv
// alu_seq_if: operation issue / result bus between the datapath controller
// and alu_seq.
//   start          issue strobe; OP/Acc_in/Reg_in are sampled with it
//   OP[3:0]        opcode
//   Acc_in[W-1:0]  accumulator operand A
//   Reg_in[W-1:0]  register-file operand R
//   OUT[W-1:0]     result register
//   c_flag         carry/overflow flag register
//   busy           multi-cycle operation iterating
//   done           one-cycle pulse, OUT/c_flag hold the final result
// master = controller side, slave = alu_seq side.
interface alu_seq_if #(
  parameter int unsigned W = 8
);
  logic         start;
  logic [3:0]   OP;
  logic [W-1:0] Acc_in;
  logic [W-1:0] Reg_in;
  logic [W-1:0] OUT;
  logic         c_flag;
  logic         busy;
  logic         done;

  modport master (
    output start, OP, Acc_in, Reg_in,
    input  OUT, c_flag, busy, done
  );

  modport slave (
    input  start, OP, Acc_in, Reg_in,
    output OUT, c_flag, busy, done
  );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: multi-cycle accumulator-machine ALU with an internal carry flag,
// bit-serial shifts and an iterative shift-add multiply.
//   CLK    rising-edge clock
//   reset  synchronous, active-high reset
//   bus    alu_seq_if.slave: start/OP/Acc_in/Reg_in in, OUT/c_flag/busy/done out
// Single-cycle ops finish at the edge that samples start. Shifts and MUL do
// their first iteration at that edge too, then one iteration per RUN cycle,
// so an n-iteration op pulses done n cycles after start.
module alu_seq #(
  parameter int unsigned W = 8
) (
  input logic       CLK,
  input logic       reset,
  alu_seq_if.slave  bus
);

  localparam int unsigned SW = $clog2(W) + 1;

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  localparam logic [3:0] OP_PASSR = 4'b0000;
  localparam logic [3:0] OP_PASSA = 4'b0001;
  localparam logic [3:0] OP_XOR   = 4'b0010;
  localparam logic [3:0] OP_NAND  = 4'b0011;
  localparam logic [3:0] OP_SHL   = 4'b0100;
  localparam logic [3:0] OP_SHR   = 4'b0101;
  localparam logic [3:0] OP_LSN   = 4'b0110;
  localparam logic [3:0] OP_EQL   = 4'b0111;
  localparam logic [3:0] OP_ADD   = 4'b1000;
  localparam logic [3:0] OP_SUB   = 4'b1001;
  localparam logic [3:0] OP_CLRC  = 4'b1010;
  localparam logic [3:0] OP_MUL   = 4'b1011;

  // One shift-add step on {hi, lo}: lo starts as the multiplier and is
  // consumed LSB first while the partial product grows into hi.
  function automatic logic [2*W-1:0] mul_step(input logic [2*W-1:0] p,
                                               input logic [W-1:0]   a);
    logic [W:0] hi;
    hi = {1'b0, p[2*W-1:W]} + (p[0] ? {1'b0, a} : {(W+1){1'b0}});
    return {hi, p[W-1:1]};
  endfunction

  logic [0:0]     state_q, state_d;
  logic [W-1:0]   out_q, out_d;
  logic           c_q, c_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic [SW-1:0]  cnt_q, cnt_d;
  logic [W-1:0]   sh_q, sh_d;
  logic [2*W-1:0] prod_q, prod_d;
  logic [3:0]     op_q, op_d;
  logic [W-1:0]   a_q, a_d;

  // Shift count saturates at W: beyond that every bit has been shifted out.
  logic [SW-1:0]  shamt;
  logic [W:0]     add_sum;
  logic           lsn_lt;
  logic [W-1:0]   sh_first;
  logic [W-1:0]   sh_next;
  logic [2*W-1:0] prod_first;
  logic [2*W-1:0] prod_next;

  assign shamt      = (bus.Reg_in >= W'(W)) ? SW'(W) : SW'(bus.Reg_in);
  assign add_sum    = {1'b0, bus.Acc_in} + {1'b0, bus.Reg_in} + (W+1)'(c_q);
  assign lsn_lt     = $signed(bus.Acc_in) < $signed(bus.Reg_in);
  assign sh_first   = (bus.OP == OP_SHL) ? (bus.Acc_in << 1) : (bus.Acc_in >> 1);
  assign sh_next    = (op_q == OP_SHL) ? (sh_q << 1) : (sh_q >> 1);
  assign prod_first = mul_step({{W{1'b0}}, bus.Reg_in}, bus.Acc_in);
  assign prod_next  = mul_step(prod_q, a_q);

  // State and result registers.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q <= S_IDLE;
      out_q   <= '0;
      c_q     <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cnt_q   <= '0;
      sh_q    <= '0;
      prod_q  <= '0;
      op_q    <= '0;
      a_q     <= '0;
    end else begin
      state_q <= state_d;
      out_q   <= out_d;
      c_q     <= c_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      prod_q  <= prod_d;
      op_q    <= op_d;
      a_q     <= a_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d = state_q;
    out_d   = out_q;
    c_d     = c_q;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    prod_d  = prod_q;
    op_d    = op_q;
    a_d     = a_q;

    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          op_d   = bus.OP;
          a_d    = bus.Acc_in;
          done_d = 1'b1;
          case (bus.OP)
            OP_PASSR: out_d = bus.Reg_in;
            OP_PASSA: out_d = bus.Acc_in;
            OP_XOR:   out_d = bus.Acc_in ^ bus.Reg_in;
            OP_NAND:  out_d = ~(bus.Acc_in & bus.Reg_in);
            OP_LSN:   out_d = W'(lsn_lt);
            OP_EQL:   out_d = W'(bus.Acc_in == bus.Reg_in);
            OP_ADD: begin
              out_d = add_sum[W-1:0];
              c_d   = add_sum[W];
            end
            OP_SUB:   out_d = bus.Acc_in - bus.Reg_in;
            OP_CLRC:  c_d   = 1'b0;
            OP_SHL, OP_SHR: begin
              if (shamt == '0) begin
                out_d = bus.Acc_in;
              end else if (shamt == SW'(1)) begin
                out_d = sh_first;
              end else begin
                sh_d    = sh_first;
                cnt_d   = shamt - SW'(1);
                state_d = S_RUN;
                busy_d  = 1'b1;
                done_d  = 1'b0;
              end
            end
            OP_MUL: begin
              // W >= 2, so MUL always has iterations left after this one.
              prod_d  = prod_first;
              cnt_d   = SW'(W - 1);
              state_d = S_RUN;
              busy_d  = 1'b1;
              done_d  = 1'b0;
            end
            default:  out_d = '0;
          endcase
        end
      end

      S_RUN: begin
        if (op_q == OP_MUL) begin
          prod_d = prod_next;
        end else begin
          sh_d = sh_next;
        end
        if (cnt_q == SW'(1)) begin
          // Last iteration: publish the result and return to IDLE.
          if (op_q == OP_MUL) begin
            out_d = prod_next[W-1:0];
            c_d   = |prod_next[2*W-1:W];
          end else begin
            out_d = sh_next;
          end
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else begin
          cnt_d  = cnt_q - SW'(1);
          busy_d = 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign bus.OUT    = out_q;
  assign bus.c_flag = c_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;

endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed-vector bench for alu_seq (W=8). Each op is issued in
// the cycle where the previous done is high, so back-to-back issue is
// exercised throughout. Inputs are driven and outputs sampled on negedge.
module tb_alu_seq;

  localparam int unsigned W      = 8;
  localparam int unsigned MAX_LAT = 20;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  alu_seq_if #(.W(W)) bus ();

  alu_seq #(.W(W)) u_dut (
    .CLK   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Issue one op at the current negedge, then track it to done. With poke set,
  // a PASSR start is driven mid-RUN; it must be ignored.
  task automatic run_op(input string tag, input logic [3:0] op, input logic [7:0] a,
                        input logic [7:0] r, input int exp_lat, input logic [7:0] exp_out,
                        input logic exp_c, input bit poke);
    int   lat;
    logic busy1;
    bus.start  = 1'b1;
    bus.OP     = op;
    bus.Acc_in = a;
    bus.Reg_in = r;
    @(negedge clk);
    bus.start  = 1'b0;
    bus.OP     = 4'b0000;
    bus.Acc_in = 8'h5C;
    bus.Reg_in = 8'hEE;
    lat   = 1;
    busy1 = bus.busy;
    while (!bus.done && lat < MAX_LAT) begin
      bus.start = poke && (lat == 3);
      @(negedge clk);
      bus.start = 1'b0;
      lat++;
    end
    chk({tag, "_busy1"}, 32'(busy1), 32'(exp_lat > 1));
    chk({tag, "_lat"},   32'(lat),   32'(exp_lat));
    chk({tag, "_out"},   32'(bus.OUT), 32'(exp_out));
    chk({tag, "_c"},     32'(bus.c_flag), 32'(exp_c));
    chk({tag, "_busy_end"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    int lat;
    total      = 0;
    bad        = 0;
    reset      = 1'b1;
    bus.start  = 1'b0;
    bus.OP     = 4'b0000;
    bus.Acc_in = '0;
    bus.Reg_in = '0;
    repeat (2) @(negedge clk);
    reset = 1'b0;

    chk("rst_out",  32'(bus.OUT),    32'h00);
    chk("rst_c",    32'(bus.c_flag), 32'd0);
    chk("rst_busy", 32'(bus.busy),   32'd0);
    chk("rst_done", 32'(bus.done),   32'd0);

    //      tag        op        A      R      lat out    c     poke
    run_op("passr",  4'b0000, 8'h11, 8'h5A, 1, 8'h5A, 1'b0, 1'b0);
    run_op("clrc",   4'b1010, 8'h22, 8'h33, 1, 8'h5A, 1'b0, 1'b0);
    run_op("add_ov", 4'b1000, 8'hFF, 8'h01, 1, 8'h00, 1'b1, 1'b0);
    run_op("sub",    4'b1001, 8'h05, 8'h07, 1, 8'hFE, 1'b1, 1'b0);
    run_op("rsvd",   4'b1101, 8'h12, 8'h34, 1, 8'h00, 1'b1, 1'b0);
    run_op("lsn_a",  4'b0110, 8'h80, 8'h01, 1, 8'h01, 1'b1, 1'b0);
    run_op("add_ci", 4'b1000, 8'h10, 8'h20, 1, 8'h31, 1'b0, 1'b0);
    run_op("shl3",   4'b0100, 8'h81, 8'h03, 3, 8'h08, 1'b0, 1'b0);
    run_op("shr9",   4'b0101, 8'h81, 8'h09, 8, 8'h00, 1'b0, 1'b0);
    run_op("shl0",   4'b0100, 8'h81, 8'h00, 1, 8'h81, 1'b0, 1'b0);
    run_op("shr1",   4'b0101, 8'h81, 8'h01, 1, 8'h40, 1'b0, 1'b0);
    run_op("shr2",   4'b0101, 8'h81, 8'h02, 2, 8'h20, 1'b0, 1'b0);
    run_op("mul_a",  4'b1011, 8'd13, 8'd20, 8, 8'h04, 1'b1, 1'b1);
    run_op("lsn_b",  4'b0110, 8'h7F, 8'h80, 1, 8'h00, 1'b1, 1'b0);
    run_op("eql_t",  4'b0111, 8'hC3, 8'hC3, 1, 8'h01, 1'b1, 1'b0);
    run_op("eql_f",  4'b0111, 8'hC3, 8'hC2, 1, 8'h00, 1'b1, 1'b0);
    run_op("nand",   4'b0011, 8'hF0, 8'hFF, 1, 8'h0F, 1'b1, 1'b0);
    run_op("xor",    4'b0010, 8'h3C, 8'h0F, 1, 8'h33, 1'b1, 1'b0);
    run_op("passa",  4'b0001, 8'h9A, 8'h00, 1, 8'h9A, 1'b1, 1'b0);
    run_op("mul_b",  4'b1011, 8'd7,  8'd9,  8, 8'h3F, 1'b0, 1'b1);
    run_op("lsn_c",  4'b0110, 8'hFF, 8'h00, 1, 8'h01, 1'b0, 1'b0);
    run_op("mul_ff", 4'b1011, 8'hFF, 8'hFF, 8, 8'h01, 1'b1, 1'b0);
    run_op("pass77", 4'b0000, 8'h00, 8'h77, 1, 8'h77, 1'b1, 1'b0);

    // Abort a MUL in its 4th cycle with reset.
    bus.start  = 1'b1;
    bus.OP     = 4'b1011;
    bus.Acc_in = 8'hFF;
    bus.Reg_in = 8'hFF;
    @(negedge clk);
    bus.start = 1'b0;
    lat = 1;
    while (lat < 4) begin
      @(negedge clk);
      lat++;
    end
    chk("abort_busy_pre", 32'(bus.busy), 32'd1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort_busy", 32'(bus.busy),   32'd0);
    chk("abort_done", 32'(bus.done),   32'd0);
    chk("abort_out",  32'(bus.OUT),    32'h00);
    chk("abort_c",    32'(bus.c_flag), 32'd0);

    run_op("mul_post", 4'b1011, 8'd7, 8'd9, 8, 8'h3F, 1'b0, 1'b0);
    run_op("add_post", 4'b1000, 8'h01, 8'h02, 1, 8'h03, 1'b0, 1'b0);

    // No further done pulse once idle.
    @(negedge clk);
    chk("idle_done", 32'(bus.done), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
